// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives datapath strobes.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes trap instead of acting as NOP).
module mc_ctrl_fsm #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       branch,
  output logic       jump,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       i_or_d,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       mem_timeout
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wait_q, wait_d;
  logic                   is_r_s, is_addi_s, is_ori_s, is_lw_s, is_sw_s, is_beq_s, is_j_s;
  logic                   known_s, wait_state_s, timeout_s;
  logic                   unused_zero_s;

  // The branch decision itself is made in the npc unit; the FSM never looks at zero.
  assign unused_zero_s = zero;

  assign is_r_s    = (opcode == OP_R);
  assign is_addi_s = (opcode == OP_ADDI);
  assign is_ori_s  = (opcode == OP_ORI);
  assign is_lw_s   = (opcode == OP_LW);
  assign is_sw_s   = (opcode == OP_SW);
  assign is_beq_s  = (opcode == OP_BEQ);
  assign is_j_s    = (opcode == OP_J);
  assign known_s   = is_r_s | is_addi_s | is_ori_s | is_lw_s | is_sw_s | is_beq_s;

  assign wait_state_s = (state_q == S_IF) || (state_q == S_MEM);
  assign timeout_s    = wait_state_s && !mem_ready && (wait_q == TIMEOUT_W'(TIMEOUT_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (timeout_s)      state_d = S_IF;
        else if (mem_ready) state_d = S_ID;
        else                state_d = S_IF;
      end
      S_ID: begin
        if (known_s)     state_d = S_EX;
        else if (is_j_s) state_d = S_IF;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_IF;
`endif
        end
      end
      S_EX: begin
        if (is_r_s || is_addi_s || is_ori_s) state_d = S_WB;
        else if (is_lw_s || is_sw_s)         state_d = S_MEM;
        else                                 state_d = S_IF;
      end
      S_MEM: begin
        if (timeout_s)      state_d = S_IF;
        else if (mem_ready) state_d = is_lw_s ? S_WB : S_IF;
        else                state_d = S_MEM;
      end
      S_WB:   state_d = S_IF;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IF;
    endcase
  end

  // Wait counter only advances while stalled in place; any progress or abort clears it.
  always_comb begin
    if (wait_state_s && !mem_ready && !timeout_s && (state_d == state_q)) begin
      wait_d = wait_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_d = '0;
    end
  end

  always_comb begin
    pc_wr       = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    ir_wr       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    i_or_d      = 1'b0;
    reg_wr      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = 2'b00;
    mem_timeout = 1'b0;
    // Gating on rst_n keeps a mid-instruction reset from committing any write.
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_rd      = 1'b1;
          ir_wr       = mem_ready;
          mem_timeout = timeout_s;
        end
        S_ID: begin
          if (is_j_s) begin
            jump  = 1'b1;
            pc_wr = 1'b1;
          end else if (!known_s) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            pc_wr = 1'b0;
`else
            pc_wr = 1'b1;
`endif
          end else begin
            pc_wr = 1'b0;
          end
        end
        S_EX: begin
          if (is_r_s) begin
            alu_src_b = 2'd0;
            alu_op    = 2'b10;
          end else if (is_addi_s || is_lw_s || is_sw_s) begin
            alu_src_b = 2'd1;
            alu_op    = 2'b00;
          end else if (is_ori_s) begin
            alu_src_b = 2'd2;
            alu_op    = 2'b11;
          end else if (is_beq_s) begin
            alu_src_b = 2'd0;
            alu_op    = 2'b01;
            branch    = 1'b1;
            pc_wr     = 1'b1;
          end else begin
            alu_op    = 2'b00;
          end
        end
        S_MEM: begin
          i_or_d      = 1'b1;
          mem_rd      = is_lw_s;
          mem_wr      = is_sw_s;
          pc_wr       = is_sw_s & mem_ready;
          mem_timeout = timeout_s;
        end
        S_WB: begin
          reg_wr     = 1'b1;
          pc_wr      = 1'b1;
          reg_dst    = is_r_s;
          mem_to_reg = is_lw_s;
        end
        default: begin
          pc_wr = 1'b0;
        end
      endcase
    end else begin
      pc_wr = 1'b0;
    end
  end

  assign state      = state_q;
  assign instr_done = pc_wr;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`endif

endmodule
